// File: rtl/ex_mult_pkg.sv
// Shared types and helpers for the iterative EX-stage multiplier.
package ex_mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Elaboration-time ceil(log2(v)); sizes the iteration counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: acc + a * slice, truncated to the accumulator width.
module mult_step #(
  parameter int unsigned ACC_W = 64,
  parameter int unsigned BITS  = 4
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] a_i,
  input  logic [BITS-1:0]  slice_i,
  output logic [ACC_W-1:0] sum_o
);

  logic [ACC_W-1:0] pp;

  always_comb begin
    pp = '0;
    for (int j = 0; j < BITS; j++) begin
      if (slice_i[j]) pp = pp + (a_i << j);
    end
    sum_o = acc_i + pp;
  end

endmodule

// File: rtl/ex_mult_iter.sv
// Iterative shift-add multiplier for the EX stage; stalls the front of the pipe while busy.
// Define MULT_HIGH_EN to widen the accumulator and return the upper half when sel_hi_i is set.
module ex_mult_iter
  import ex_mult_pkg::*;
#(
  parameter int unsigned      DATA_W         = 64,
  parameter int unsigned      BITS_PER_CYCLE = 4,
  parameter logic [DATA_W-1:0] PRESET_VAL    = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic              sel_hi_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              stall_o
);

  localparam int unsigned LAT   = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (clog2(LAT) > 0) ? clog2(LAT) : 1;
`ifdef MULT_HIGH_EN
  localparam int unsigned ACC_W = 2 * DATA_W;
`else
  localparam int unsigned ACC_W = DATA_W;
`endif

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   a_q;
  logic [DATA_W-1:0]  b_q;
  logic [DATA_W-1:0]  result_q;
  logic [ACC_W-1:0]   acc_nxt;
  logic [DATA_W-1:0]  final_res;
  logic               launch;

  assign launch = start_i & ~flush_i;

  // a_q is pre-shifted each cycle, so the step always weights the slice at bit 0.
  mult_step #(
    .ACC_W (ACC_W),
    .BITS  (BITS_PER_CYCLE)
  ) u_step (
    .acc_i   (acc_q),
    .a_i     (a_q),
    .slice_i (b_q[BITS_PER_CYCLE-1:0]),
    .sum_o   (acc_nxt)
  );

`ifdef MULT_HIGH_EN
  logic sel_q;
  assign final_res = sel_q ? acc_nxt[ACC_W-1:DATA_W] : acc_nxt[DATA_W-1:0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sel_q <= 1'b0;
    end else if (state_q == StIdle && launch) begin
      sel_q <= sel_hi_i;
    end
  end
`else
  logic unused_sel_hi;
  assign unused_sel_hi = sel_hi_i;
  assign final_res     = acc_nxt;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= PRESET_VAL;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            a_q     <= ACC_W'(op_a_i);
            b_q     <= op_b_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else begin
            acc_q <= acc_nxt;
            a_q   <= a_q << BITS_PER_CYCLE;
            b_q   <= b_q >> BITS_PER_CYCLE;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(LAT - 1)) begin
              result_q <= final_res;
              state_q  <= StDone;
            end
          end
        end
        // start_i still shows the finished instruction here, so it is ignored.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_o = result_q;
  assign done_o   = (state_q == StDone);
  assign busy_o   = (state_q == StRun);
  assign stall_o  = (state_q == StRun) | ((state_q == StIdle) & launch);

endmodule

// File: tb/tb_ex_mult_iter.sv
// Directed + random bench for ex_mult_iter against a plain-arithmetic product model.
module tb_ex_mult_iter;

  localparam logic [63:0] PRESET0 = 64'hA5A5_0000_1234_5A5A;

  logic        clk;
  logic        arst_n;
  logic        start0;
  logic        start1;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        sel_hi;
  logic        flush;
  logic [63:0] res0;
  logic [63:0] res1;
  logic        done0, busy0, stall0;
  logic        done1, busy1, stall1;

  int n_checks = 0;
  int n_err    = 0;

  ex_mult_iter #(
    .DATA_W         (64),
    .BITS_PER_CYCLE (4),
    .PRESET_VAL     (PRESET0)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start_i  (start0),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .sel_hi_i (sel_hi),
    .flush_i  (flush),
    .result_o (res0),
    .done_o   (done0),
    .busy_o   (busy0),
    .stall_o  (stall0)
  );

  ex_mult_iter #(
    .DATA_W         (64),
    .BITS_PER_CYCLE (1),
    .PRESET_VAL     (64'h0)
  ) dut1 (
    .clk      (clk),
    .arst_n   (arst_n),
    .start_i  (start1),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .sel_hi_i (sel_hi),
    .flush_i  (flush),
    .result_o (res1),
    .done_o   (done1),
    .busy_o   (busy1),
    .stall_o  (stall1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: full 128-bit unsigned product, pick a half.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic hi);
    logic [127:0] p;
    p = {64'h0, a} * {64'h0, b};
    return hi ? p[127:64] : p[63:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered mid-cycle with the DUT ready to accept; leaves mid-cycle one cycle after DONE.
  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                     input bit one, input bit keep, input string tag);
    int done_cyc;
    int lat;
    bit stall_ok;
    bit busy_ok;
    lat      = one ? 64 : 16;
    done_cyc = -1;
    stall_ok = 1'b1;
    busy_ok  = 1'b1;
    op_a = a;
    op_b = b;
    if (one) start1 = 1'b1;
    else start0 = 1'b1;
    for (int c = 0; c < 150; c++) begin
      #1;
      if (one ? done1 : done0) begin
        done_cyc = c;
        break;
      end
      if (!(one ? stall1 : stall0)) stall_ok = 1'b0;
      if (c > 0 && !(one ? busy1 : busy0)) busy_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    if (!keep) begin
      start0 = 1'b0;
      start1 = 1'b0;
    end
    #1;
    chk({tag, " done_cycle"}, 64'(done_cyc), 64'(lat + 1));
    chk({tag, " stall_before_done"}, 64'(stall_ok), 64'd1);
    chk({tag, " busy_in_run"}, 64'(busy_ok), 64'd1);
    chk({tag, " stall_in_done"}, 64'(one ? stall1 : stall0), 64'd0);
    chk({tag, " result"}, one ? res1 : res0, exp);
    @(posedge clk);
    #2;
    chk({tag, " done_single_pulse"}, 64'(one ? done1 : done0), 64'd0);
    chk({tag, " result_hold"}, one ? res1 : res0, exp);
  endtask

  initial begin
    logic [63:0] a, b, prev;
    bit seen;

    arst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    op_a   = '0;
    op_b   = '0;
    sel_hi = 1'b0;
    flush  = 1'b0;
    #12;
    chk("reset result", res0, PRESET0);
    chk("reset done", 64'(done0), 64'd0);
    chk("reset busy", 64'(busy0), 64'd0);
    chk("reset stall", 64'(stall0), 64'd0);
    chk("reset result bpc1", res1, 64'd0);
    arst_n = 1'b1;
    @(posedge clk);
    #2;

    run(64'd3, 64'd5, 64'd15, 1'b0, 1'b0, "basic");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "overflow");
`ifdef MULT_HIGH_EN
    sel_hi = 1'b1;
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0, 1'b0, "overflow_hi");
    sel_hi = 1'b0;
`endif
    run(64'd0, 64'h1234, 64'd0, 1'b0, 1'b0, "zero");
    run(64'd11, 64'd13, 64'd143, 1'b0, 1'b0, "pre_flush");

    // Flush in RUN cycle 5: back to IDLE, no done, result untouched.
    prev   = res0;
    op_a   = 64'h1234_5678;
    op_b   = 64'h9ABC;
    start0 = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    start0 = 1'b0;
    flush  = 1'b1;
    #1;
    chk("flush busy_before", 64'(busy0), 64'd1);
    @(posedge clk);
    #2;
    flush = 1'b0;
    chk("flush stall_after", 64'(stall0), 64'd0);
    chk("flush busy_after", 64'(busy0), 64'd0);
    chk("flush result_kept", res0, prev);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done0) seen = 1'b1;
      @(posedge clk);
      #2;
    end
    chk("flush no_done", 64'(seen), 64'd0);
    chk("flush result_still", res0, prev);

    // Asynchronous reset in RUN cycle 8.
    op_a   = 64'hDEAD;
    op_b   = 64'hBEEF;
    start0 = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    start0 = 1'b0;
    arst_n = 1'b0;
    #1;
    chk("midreset result", res0, PRESET0);
    chk("midreset done", 64'(done0), 64'd0);
    chk("midreset busy", 64'(busy0), 64'd0);
    chk("midreset stall", 64'(stall0), 64'd0);
    #2;
    arst_n = 1'b1;
    @(posedge clk);
    #2;
    run(64'd7, 64'd9, 64'd63, 1'b0, 1'b0, "after_reset");

    // Back-to-back: start held through DONE, next op begins in the following IDLE cycle.
    run(64'd2, 64'd3, 64'd6, 1'b0, 1'b1, "b2b_first");
    run(64'd4, 64'd5, 64'd20, 1'b0, 1'b0, "b2b_second");

    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      run(a, b, model(a, b, 1'b0), 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    run(64'd0, 64'h1234, 64'd0, 1'b1, 1'b0, "bpc1_zero");
    for (int i = 0; i < 2; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      run(a, b, model(a, b, 1'b0), 1'b1, 1'b0, $sformatf("bpc1_rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mult_iter.md
Name: ex_mult_iter

Overview:
- Iterative 64-bit multiplier in the EX stage of the basic 5-stage pipeline.
- Consumes operands and the MUL control bit from the ID/EX pipeline register; produces the product for the EX/MEM pipeline register.
- Drives stall_o, which the pipeline control logic uses to deassert the enable of the PC, IF/ID and ID/EX registers and to gate the EX/MEM enable while a multiply is in flight.
- Shift-add datapath, BITS_PER_CYCLE multiplier bits retired per clock.

Parameters:
- DATA_W, 64, operand and result width.
- BITS_PER_CYCLE, 4, multiplier bits retired per cycle. Legal values: 1, 2, 4, 8. Must divide DATA_W.
- PRESET_VAL, 0, reset value of result_o.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- arst_n, in, 1, reset; asynchronous, active-low.
- start_i, in, 1, the instruction held in ID/EX is a multiply (qualified by the ID/EX valid bit).
- op_a_i, in, DATA_W, multiplicand (rs1 value from ID/EX).
- op_b_i, in, DATA_W, multiplier (rs2 value from ID/EX).
- sel_hi_i, in, 1, select the upper product half (used only with MULT_HIGH_EN).
- flush_i, in, 1, branch/jump taken in MEM; kills the in-flight multiply.
- result_o, out, DATA_W, product; valid when done_o=1.
- done_o, out, 1, one-cycle pulse; result_o valid.
- busy_o, out, 1, FSM in RUN.
- stall_o, out, 1, hold the upstream pipeline registers.

Behaviour:
- Reset (arst_n=0, any time, including mid-RUN): state=IDLE, cnt=0, accumulator=0, result_o=PRESET_VAL, done_o=0, busy_o=0, stall_o=0. The operation in progress is discarded.
- Latency constant LAT = DATA_W/BITS_PER_CYCLE; 16 at the default settings.
- IDLE:
  - If start_i=1 and flush_i=0: latch op_a_i, op_b_i and sel_hi_i; clear the accumulator; cnt=0; next state RUN. stall_o=1 combinationally during this cycle.
  - Otherwise remain in IDLE with stall_o=0.
- RUN:
  - Each cycle add op_a shifted by (cnt*BITS_PER_CYCLE), multiplied by the current BITS_PER_CYCLE-bit multiplier slice, into the accumulator.
  - cnt increments; busy_o=1; stall_o=1.
  - When cnt==LAT-1, next state is DONE.
- DONE (exactly one cycle):
  - done_o=1; result_o holds the final product; stall_o=0, so ID/EX and EX/MEM advance at the end of this cycle.
  - start_i is ignored here because it still reflects the finished instruction.
  - Next state IDLE.
- result_o value: low DATA_W bits of the unsigned product. Low bits are identical for signed and unsigned operands, so this implements RV64 MUL.
- result_o holds its value until the next DONE.
- Accumulator width: 2*DATA_W with MULT_HIGH_EN, DATA_W without it (overflow discarded).
- Stall timing: start_i rises in cycle 0 → stall_o high in cycles 0..LAT → done_o high in cycle LAT+1.
- No early termination; zero operands take the full latency.
- flush_i=1 in IDLE or RUN: next state IDLE, no done_o, result_o unchanged, stall_o drops the next cycle.
- flush_i in DONE: done_o still pulses; EX/MEM squashing is the pipeline control's job.
- Back-to-back multiplies: the second one starts in the IDLE cycle after DONE. There is no bubble beyond that single IDLE cycle.

Optional Feature:
- Macro: MULT_HIGH_EN.
- Defined: 2*DATA_W accumulator; sel_hi_i=1 returns product bits [2*DATA_W-1:DATA_W] (unsigned, MULHU). Latency is unchanged.
- Undefined: DATA_W accumulator; sel_hi_i is ignored; result is always the low half.

Decomposition:
- Package ex_mult_pkg:
  - state enum {IDLE, RUN, DONE};
  - function clog2 for the cnt width;
  - localparam LAT derived from the parameters.
- Sub-module mult_step: combinational partial-product generator plus adder for one BITS_PER_CYCLE slice; instantiated once in the RUN datapath.

Test Plan:
- Basic multiply: reset, then start_i=1 with op_a=3, op_b=5, BITS_PER_CYCLE=4 → stall_o high in cycles 0..16, done_o pulse in cycle 17, result_o=15.
- Overflow: op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2 → result_o=0xFFFF_FFFF_FFFF_FFFE. With MULT_HIGH_EN and sel_hi_i=1 → result_o=1.
- Flush: flush_i pulsed in RUN cycle 5 → state IDLE, no done_o, stall_o=0 the next cycle, result_o keeps its previous value.
- Reset mid-operation: arst_n low in RUN cycle 8 → all outputs at reset values immediately (asynchronous). A new multiply of 7×9 then completes with result 63.
- Back-to-back: 2×3 then 4×5 → done pulses 18 cycles apart with results 6 then 20, and stall_o low only during each DONE cycle.
- Zero operand: op_a=0, op_b=0x1234 → full latency, result_o=0. Also with BITS_PER_CYCLE=1 → done_o in cycle 65.
